// File: rtl/branch_redirect_if.sv
// Execute-to-fetch redirect bundle: resolved branch inputs, PC-override outputs and branch statistics.
interface branch_redirect_if #(
   parameter int instSize = 24
) ();
   logic                  brValid;
   logic                  brTaken;
   logic [instSize+7:0]   brTarget;
   logic                  stall;
   logic                  pcWrEn;
   logic [instSize+7:0]   newPc;
   logic                  flush;
   logic                  busy;
   logic [15:0]           branchCount;
   logic [15:0]           takenCount;

   modport master (
      output brValid, brTaken, brTarget, stall,
      input  pcWrEn, newPc, flush, busy, branchCount, takenCount
   );

   modport slave (
      input  brValid, brTaken, brTarget, stall,
      output pcWrEn, newPc, flush, busy, branchCount, takenCount
   );
endinterface

// File: rtl/branch_redirect.sv
// Control-flow redirect unit: turns a taken branch into a one-cycle PC override for fetch,
// then squashes younger instructions for squashDepth cycles in total; keeps saturating stats.
module branch_redirect #(
   parameter int instSize    = 24,
   parameter int squashDepth = 2
) (
   input logic             clk,
   input logic             reset,
   branch_redirect_if.slave br
);
   localparam int pcw = instSize + 8;
   localparam logic [3:0] squash_init = 4'(squashDepth - 2);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      HOLD   = 2'd2,
      SQUASH = 2'd3
   } state_t;

   state_t            state_r;
   logic [3:0]        squash_cnt_r;
   logic [pcw-1:0]    new_pc_r;
   logic              pc_wr_en_r;
   logic              flush_r;
   logic              busy_r;
   logic [15:0]       branch_count_r;
   logic [15:0]       taken_count_r;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Redirect sequencer; outputs are set on the transition into each state so they stay registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= IDLE;
         squash_cnt_r   <= 4'd0;
         new_pc_r       <= '0;
         pc_wr_en_r     <= 1'b0;
         flush_r        <= 1'b0;
         busy_r         <= 1'b0;
         branch_count_r <= 16'd0;
         taken_count_r  <= 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (br.brValid && !br.stall) begin
                  branch_count_r <= sat_inc(branch_count_r);
                  if (br.brTaken) begin
                     taken_count_r <= sat_inc(taken_count_r);
                     new_pc_r      <= br.brTarget;
                     squash_cnt_r  <= squash_init;
                     state_r       <= ISSUE;
                     pc_wr_en_r    <= 1'b1;
                     flush_r       <= 1'b1;
                     busy_r        <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               state_r    <= HOLD;
               pc_wr_en_r <= 1'b0;
            end
            // Fetch samples newPc during HOLD, so new_pc_r is left untouched here.
            HOLD: begin
               if (squash_cnt_r != 4'd0) begin
                  state_r <= SQUASH;
               end else begin
                  state_r <= IDLE;
                  flush_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            SQUASH: begin
               if (squash_cnt_r <= 4'd1) begin
                  squash_cnt_r <= 4'd0;
                  state_r      <= IDLE;
                  flush_r      <= 1'b0;
                  busy_r       <= 1'b0;
               end else begin
                  squash_cnt_r <= squash_cnt_r - 4'd1;
               end
            end
            default: begin
               state_r      <= IDLE;
               squash_cnt_r <= 4'd0;
               pc_wr_en_r   <= 1'b0;
               flush_r      <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   assign br.pcWrEn      = pc_wr_en_r;
   assign br.newPc       = new_pc_r;
   assign br.flush       = flush_r;
   assign br.busy        = busy_r;
   assign br.branchCount = branch_count_r;
   assign br.takenCount  = taken_count_r;
endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: two instances (squashDepth 2 and 4) share one stimulus stream and
// are checked against a countdown model, a directed vector table and hand-written corner sequences.
module tb_branch_redirect;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_valid;
   logic        br_taken;
   logic        stall;
   logic [31:0] br_target;

   always #5 clk = ~clk;

   branch_redirect_if #(.instSize(24)) if2 ();
   branch_redirect_if #(.instSize(24)) if4 ();

   assign if2.brValid  = br_valid;
   assign if2.brTaken  = br_taken;
   assign if2.brTarget = br_target;
   assign if2.stall    = stall;
   assign if4.brValid  = br_valid;
   assign if4.brTaken  = br_taken;
   assign if4.brTarget = br_target;
   assign if4.stall    = stall;

   branch_redirect #(.instSize(24), .squashDepth(2)) dut2 (.clk(clk), .reset(rst_n), .br(if2));
   branch_redirect #(.instSize(24), .squashDepth(4)) dut4 (.clk(clk), .reset(rst_n), .br(if4));

   int n_vec = 0;
   int n_err = 0;

   // Reference model: remaining flush cycles per instance, plus target and statistics.
   int          dep [2] = '{2, 4};
   int          left [2];
   logic [31:0] m_npc [2];
   int          m_bc [2];
   int          m_tc [2];

   typedef struct {
      logic        v;
      logic        t;
      logic        s;
      logic [31:0] tgt;
      logic        e_pc;
      logic        e_fl;
      logic [31:0] e_npc;
      logic [15:0] e_bc;
      logic [15:0] e_tc;
   } vec_t;

   vec_t tbl [12];

   task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (squashDepth=%0d) t=%0t: got %h, expected %h", name, dep[d], $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         left[d]  = 0;
         m_npc[d] = 32'd0;
         m_bc[d]  = 0;
         m_tc[d]  = 0;
      end
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (left[d] == 0) begin
               if (br_valid && !stall) begin
                  m_bc[d] = (m_bc[d] < 65535) ? m_bc[d] + 1 : 65535;
                  if (br_taken) begin
                     m_tc[d]  = (m_tc[d] < 65535) ? m_tc[d] + 1 : 65535;
                     m_npc[d] = br_target;
                     left[d]  = dep[d];
                  end
               end
            end else begin
               left[d] = left[d] - 1;
            end
         end
      end
   endtask

   task automatic check_all();
      logic        pcw, fl, bs;
      logic [31:0] npc;
      logic [15:0] bc, tc;
      for (int d = 0; d < 2; d++) begin
         pcw = (d == 0) ? if2.pcWrEn      : if4.pcWrEn;
         fl  = (d == 0) ? if2.flush       : if4.flush;
         bs  = (d == 0) ? if2.busy        : if4.busy;
         npc = (d == 0) ? if2.newPc       : if4.newPc;
         bc  = (d == 0) ? if2.branchCount : if4.branchCount;
         tc  = (d == 0) ? if2.takenCount  : if4.takenCount;
         cmp("pcWrEn", d, 32'(pcw), 32'(left[d] == dep[d]));
         cmp("flush", d, 32'(fl), 32'(left[d] > 0));
         cmp("busy", d, 32'(bs), 32'(left[d] > 0));
         cmp("newPc", d, npc, m_npc[d]);
         cmp("branchCount", d, 32'(bc), 32'(m_bc[d]));
         cmp("takenCount", d, 32'(tc), 32'(m_tc[d]));
      end
   endtask

   task automatic step(input logic v, input logic t, input logic [31:0] tgt, input logic s);
      @(negedge clk);
      br_valid  = v;
      br_taken  = t;
      br_target = tgt;
      stall     = s;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      step(1'b0, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Directed sequence for squashDepth=2 starting from reset: taken, not-taken, stall gating, drop in final flush cycle.
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h40,  1'b1, 1'b1, 32'h40, 16'd1, 16'd1};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h40, 16'd1, 16'd1};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h40, 16'd1, 16'd1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h999, 1'b0, 1'b0, 32'h40, 16'd2, 16'd1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 32'h40, 16'd2, 16'd1};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 32'h40, 16'd2, 16'd1};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h80,  1'b1, 1'b1, 32'h80, 16'd3, 16'd2};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h80, 16'd3, 16'd2};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'hC0,  1'b0, 1'b0, 32'h80, 16'd3, 16'd2};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'hC0,  1'b1, 1'b1, 32'hC0, 16'd4, 16'd3};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC0, 16'd4, 16'd3};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'hC0, 16'd4, 16'd3};

      rst_n     = 1'b0;
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'd0;
      stall     = 1'b0;
      model_reset();

      idle(3);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].v, tbl[i].t, tbl[i].tgt, tbl[i].s);
         cmp("tbl_pcWrEn", 0, 32'(if2.pcWrEn), 32'(tbl[i].e_pc));
         cmp("tbl_flush", 0, 32'(if2.flush), 32'(tbl[i].e_fl));
         cmp("tbl_busy", 0, 32'(if2.busy), 32'(tbl[i].e_fl));
         cmp("tbl_newPc", 0, if2.newPc, tbl[i].e_npc);
         cmp("tbl_branchCount", 0, 32'(if2.branchCount), 32'(tbl[i].e_bc));
         cmp("tbl_takenCount", 0, 32'(if2.takenCount), 32'(tbl[i].e_tc));
      end
      idle(4);

      // Branches presented while squashDepth=4 is still redirecting are dropped.
      step(1'b1, 1'b1, 32'h100, 1'b0);
      idle(1);
      step(1'b1, 1'b1, 32'h200, 1'b0);
      cmp("redir_hold_newPc", 1, if4.newPc, 32'h100);
      idle(1);
      step(1'b1, 1'b1, 32'h200, 1'b0);
      cmp("redir_last_flush", 1, 32'(if4.flush), 32'd0);
      cmp("redir_newPc_kept", 1, if4.newPc, 32'h100);
      step(1'b1, 1'b1, 32'h200, 1'b0);
      cmp("redir_accept_pcWrEn", 1, 32'(if4.pcWrEn), 32'd1);
      cmp("redir_accept_newPc", 1, if4.newPc, 32'h200);
      idle(6);

      // Asynchronous reset while both instances sit in HOLD.
      step(1'b1, 1'b1, 32'h300, 1'b0);
      idle(1);
      pulse_reset();
      cmp("rst_mid_flush", 1, 32'(if4.flush), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 32'h300, 1'b0);
         cmp("rst_no_reissue", 1, 32'(if4.pcWrEn), 32'd0);
      end

      // Random traffic checked against the model.
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
      end
      idle(6);

      // Saturation of branchCount from a clean reset.
      pulse_reset();
      for (int i = 0; i < 65537; i++) begin
         step(1'b1, 1'b0, $urandom, 1'b0);
      end
      cmp("sat_branchCount", 1, 32'(if4.branchCount), 32'h0000FFFF);
      step(1'b1, 1'b1, 32'h500, 1'b0);
      cmp("sat_branchCount_taken", 1, 32'(if4.branchCount), 32'h0000FFFF);
      cmp("sat_takenCount", 1, 32'(if4.takenCount), 32'd1);
      cmp("sat_takenCount2", 0, 32'(if2.takenCount), 32'd1);
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/branch_redirect.md
# branch_redirect

Control-flow redirect unit driving the fetch stage's PC-override inputs (`pcWrEn`, `newPc`). Accepts resolved branch/jump outcomes from execute. On a taken branch it issues a one-cycle PC-write request, holds the target stable while fetch consumes it, and flushes the younger in-flight instructions for a fixed number of cycles. Also keeps saturating branch statistics for the debug path.

## Interface
- `instSize`, 24, instruction width; PC/target width is `instSize+8` (32 bits by default)
- `squashDepth`, 2, number of consecutive flush cycles per redirect; legal range 2..15
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `brValid`  in  1  execute presents a resolved control-flow instruction this cycle
- `brTaken`  in  1  resolved outcome; meaningful only with `brValid`
- `brTarget`  in  `instSize+8`  resolved target address
- `stall`  in  1  hazard-unit stall; while high, no branch is accepted
- `pcWrEn`  out  1  PC-override request to fetch; one-cycle pulse
- `newPc`  out  `instSize+8`  registered redirect target
- `flush`  out  1  squash IF/ID and ID/EX contents
- `busy`  out  1  redirect in progress (state != IDLE)
- `branchCount`  out  16  accepted branches, saturating
- `takenCount`  out  16  accepted taken branches, saturating

## Operation
- **Reset state:** IDLE. Reset asserted gives `pcWrEn`=0, `flush`=0, `busy`=0, `newPc`=0, both counters=0.
- **Accept condition:** in IDLE, a branch is accepted when `brValid`=1 and `stall`=0.
  - `brValid` in any other state is ignored. It belongs to a squashed instruction.
  - Ignored branches leave the counters unchanged.
- **Not-taken branch:** `branchCount`+1. State stays IDLE. No other output changes.
- **Taken branch:**
  - `branchCount`+1 and `takenCount`+1.
  - `newPc` <= `brTarget`.
  - Squash counter <= `squashDepth`-2.
  - Next state ISSUE.
- **ISSUE:** `pcWrEn`=1, `flush`=1. Next state is always HOLD.
- **HOLD:** `pcWrEn`=0, `flush`=1, `newPc` unchanged.
  - Fetch delays `pcWrEn` internally by one cycle and samples `newPc` here, so `newPc` must stay valid.
  - Next state: SQUASH if squash counter != 0, else IDLE.
- **SQUASH:** `flush`=1. Squash counter decrements each cycle. Go to IDLE when it reaches 0 (checked before the decrement).
- **`newPc` updates** only on a taken accept. It holds its value through and after the redirect.
- **`stall` outside IDLE** has no effect. The redirect sequence always completes.
- **Counters:** saturate at 0xFFFF with no wrap. `takenCount` <= `branchCount` always.

## Timing
- Taken branch accepted at edge T gives:
  - `pcWrEn`=1 during cycle T+1 only.
  - `flush`=1 during cycles T+1 .. T+`squashDepth`.
  - `busy`=1 over the same window.
  - `newPc`=target from T+1 onward.
- Earliest next accept is the first IDLE cycle, T+`squashDepth`+1. A `brValid` in the final flush cycle is dropped.
- Redirect latency from accept to fetch's ROM address = target: 2 cycles (T+2).
- All outputs are registered. There is no combinational path from inputs to outputs.
- Asynchronous reset mid-sequence:
  - `pcWrEn`, `flush` and `busy` drop immediately.
  - State returns to IDLE. No partial pulse reissues after release.
- Counters update at the accept edge T and are visible in cycle T+1.

## Test plan
- **Reset:** reset=0 for 3 cycles, then release.
  - During reset: all outputs 0.
  - After release with no `brValid`: outputs stay 0.
- **Single taken branch:** `squashDepth`=2, `brTarget`=0x00000040, accepted at T.
  - T+1: `pcWrEn`=1, `newPc`=0x40, `flush`=1.
  - T+2: `pcWrEn`=0, `newPc`=0x40, `flush`=1.
  - T+3: `flush`=0, `busy`=0.
  - Counters: `branchCount`=1, `takenCount`=1.
- **Not-taken branch and stall gating:**
  - Not-taken branch: `branchCount`=1, `takenCount`=0, no `pcWrEn`/`flush`, `newPc` unchanged.
  - Taken branch with `stall`=1 for 2 cycles, then `stall`=0: accepted only on the first unstalled cycle.
- **Branch during redirect:** `squashDepth`=4.
  - Taken branch to 0x100; second taken branch to 0x200 presented at T+2 and T+4.
  - Both ignored: `newPc` stays 0x100, `flush` high T+1..T+4, `branchCount`=1.
  - Same branch at T+5 is accepted.
- **Reset mid-redirect:** reset=0 asserted during HOLD.
  - `flush`, `busy` and `newPc` go to 0 immediately.
  - After release, no `pcWrEn` pulse occurs without a new branch.
- **Saturation:** 65,537 not-taken branches, then 1 taken branch.
  - `branchCount`=0xFFFF throughout saturation; `takenCount`=1.
